cgra_ram_stream_reader: RTL

- Read-side initiator for the CGRA subsystem's single-port-pair synchronous RAM (registered read, 1-cycle latency, rd_en-gated).
- On a start command, reads `length` consecutive words beginning at `base_addr`, with addresses wrapping modulo DEPTH.
- Delivers the words in order on a valid/ready output stream with a last marker, at full throughput when the consumer is always ready.
- Used to stream configuration or spill data out of RAM into the CGRA fabric or the writeback path.

---
 rtl/cgra_ram_stream_reader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cgra_ram_stream_reader.sv
// cgra_ram_stream_reader
// Streams `length` consecutive words out of the CGRA single-port-pair RAM,
// starting at `base_addr` and wrapping modulo DEPTH, onto a valid/ready
// stream with a last marker. The RAM has a registered read (data valid the
// cycle after rd_en). Returned words land in a 2-entry FIFO, and reads are
// only issued while the FIFO plus the in-flight read leave room for the
// result, so the FIFO can never overflow.
//
// Optional feature: define RD_STREAM_CSUM_EN to add `csum`, the XOR of every
// word accepted by the consumer during the current command.
//
// Ports:
//   clk, rst_n           clock (posedge) and asynchronous active-low reset
//   start                command strobe, accepted only when idle
//   base_addr, length    command operands, sampled with an accepted start
//   busy, done           status: not idle / one-cycle completion pulse
//   rd_en, rd_addr       RAM read request
//   rd_data              RAM read data, valid the cycle after rd_en
//   out_valid, out_ready stream handshake
//   out_data, out_last   stream payload and final-word marker
//   csum                 (RD_STREAM_CSUM_EN only) XOR of delivered words
module cgra_ram_stream_reader #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [WIDTH-1:0]      rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last
`ifdef RD_STREAM_CSUM_EN
  ,
  output logic [WIDTH-1:0]      csum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remain_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  deliv_q;
  logic                  rd_vld_p1;
  logic [WIDTH-1:0]      fifo_mem_p2 [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            fifo_cnt_q;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [2:0]            occ;

  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign accept    = (state_q == S_IDLE) && start;
  assign push      = rd_vld_p1;
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  // Slots committed after this cycle: stored words plus the read in flight,
  // minus the word leaving now. A new read needs one free slot.
  assign occ       = {1'b0, fifo_cnt_q} + {2'b00, rd_vld_p1} - {2'b00, pop};
  assign rd_en     = (state_q == S_RUN) && (occ < 3'd2);
  assign rd_addr   = addr_q;
  // Gating with out_valid keeps the unreset FIFO storage off the outputs.
  assign out_data  = out_valid ? fifo_mem_p2[rd_ptr_q] : '0;
  assign out_last  = out_valid && (deliv_q == len_q - 1'b1);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (length == '0) ? S_FIN : S_RUN;
      S_RUN:   if (rd_en && (remain_q == LEN_WIDTH'(1))) state_d = S_DRAIN;
      S_DRAIN: if (pop && out_last) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      len_q      <= '0;
      deliv_q    <= '0;
      rd_vld_p1  <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      state_q <= state_d;
      // Stage p0 -> p1: read issued, RAM result arrives next cycle
      rd_vld_p1 <= rd_en;
      if (accept) begin
        addr_q   <= base_addr;
        remain_q <= length;
        len_q    <= length;
        deliv_q  <= '0;
      end else begin
        if (rd_en) begin
          addr_q   <= addr_inc(addr_q);
          remain_q <= remain_q - 1'b1;
        end
        if (pop) deliv_q <= deliv_q + 1'b1;
      end
      // Stage p1 -> p2: RAM data captured into the FIFO
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_p2[wr_ptr_q] <= rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && !pop && (fifo_cnt_q == 2'd2)));
  end

`ifdef RD_STREAM_CSUM_EN
  logic [WIDTH-1:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      csum_q <= '0;
    else if (accept) csum_q <= '0;
    else if (pop)    csum_q <= csum_q ^ out_data;
  end

  assign csum = csum_q;
`endif

endmodule
